// File: rtl/keypad_pkg.sv
// Shared key codes and debounce FSM state encoding for the keypad scanner.
package keypad_pkg;

  localparam logic [3:0] KEY_START   = 4'd3;
  localparam logic [3:0] KEY_CLEAR   = 4'd7;
  localparam logic [3:0] KEY_CONFIRM = 4'd11;
  localparam logic [3:0] KEY_ZERO    = 4'd12;
  localparam logic [3:0] KEY_NONE    = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

endpackage

// File: rtl/keypad_frame_scan.sv
// Drives the 4x4 matrix columns, synchronizes the rows and reduces each full
// scan frame to a single key code (KEY_NONE for no key or multiple keys).
module keypad_frame_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       frame_tick,
  output logic [3:0] frame_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [1:0]    acc_cnt;   // low bits seen this frame, saturates at 2
  logic [3:0]    acc_code;

  logic          last_dwell;
  logic [1:0]    hit_cnt;
  logic [1:0]    hit_row;
  logic [2:0]    total;
  logic [1:0]    sum_cnt;
  logic [3:0]    sum_code;

  assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
  assign col_out    = ~(4'b0001 << col);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    hit_cnt = '0;
    hit_row = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
        hit_row = 2'(r);
      end
    end
    total    = {1'b0, acc_cnt} + {1'b0, hit_cnt};
    sum_cnt  = (total >= 3'd2) ? 2'd2 : total[1:0];
    sum_code = (hit_cnt == 2'd1) ? {hit_row, col} : acc_code;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell      <= '0;
      col        <= '0;
      row_meta   <= 4'hF;
      row_sync   <= 4'hF;
      acc_cnt    <= '0;
      acc_code   <= KEY_NONE;
      frame_tick <= 1'b0;
      frame_code <= KEY_NONE;
    end else begin
      row_meta   <= row_in;
      row_sync   <= row_meta;
      frame_tick <= 1'b0;
      if (last_dwell) begin
        dwell <= '0;
        col   <= col + 2'd1;
        if (col == 2'd3) begin
          frame_tick <= 1'b1;
          frame_code <= (sum_cnt == 2'd1) ? sum_code : KEY_NONE;
          acc_cnt    <= '0;
          acc_code   <= KEY_NONE;
        end else begin
          acc_cnt  <= sum_cnt;
          acc_code <= sum_code;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with press/release debounce, producing the key_value/EN
// level interface consumed by the meter controller.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_value,
  output logic       EN
);

  localparam int            CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic          frame_tick;
  logic [3:0]    frame_code;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0]    cand, cand_next;
  logic [3:0]    key_next;
  logic          en_next;

  keypad_frame_scan #(.SCAN_DIV(SCAN_DIV)) u_frame_scan (
    .clk        (CLK),
    .rst        (RST),
    .row_in     (row_in),
    .col_out    (col_out),
    .frame_tick (frame_tick),
    .frame_code (frame_code)
  );

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= KEY_NONE;
      key_value <= KEY_NONE;
      EN        <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cand      <= cand_next;
      key_value <= key_next;
      EN        <= en_next;
    end
  end

  // key_value is only loaded on the accept path, where EN is still low.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    key_next   = key_value;
    en_next    = EN;
    if (frame_tick) begin
      case (state)
        IDLE: if (frame_code != KEY_NONE) begin
          if (DEBOUNCE == 1) begin
            key_next   = frame_code;
            en_next    = 1'b1;
            state_next = HELD;
          end else begin
            cand_next  = frame_code;
            cnt_next   = CW'(1);
            state_next = PRESS_DB;
          end
        end
        PRESS_DB: if (frame_code == cand) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            key_next   = cand;
            en_next    = 1'b1;
            cnt_next   = '0;
            state_next = HELD;
          end
        end else begin
          cnt_next   = '0;
          state_next = IDLE;
        end
        HELD: if (frame_code != key_value) begin
          if (DEBOUNCE == 1) begin
            en_next    = 1'b0;
            state_next = IDLE;
          end else begin
            cnt_next   = CW'(1);
            state_next = REL_DB;
          end
        end
        REL_DB: if (frame_code == key_value) begin
          cnt_next   = '0;
          state_next = HELD;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            en_next    = 1'b0;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Frame-aligned bench: a keypad matrix model drives the rows, and a streak-based
// debounce model predicts EN/key_value after every frame.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_value;
  logic        EN;

  logic [15:0] pressed = '0;   // bit r*4+c = key (r,c) pressed
  int          total = 0;
  int          bad   = 0;
  int          en_falls = 0;

  // reference model state
  logic        m_en;
  logic [3:0]  m_key;
  logic [3:0]  m_cand;
  int          m_run;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_value (key_value),
    .EN        (EN)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge EN) en_falls++;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] frame_of(input logic [15:0] m);
    if ($countones(m) != 1) return 4'hF;
    for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_key = 4'hF; m_cand = 4'hF; m_run = 0;
  endtask

  // Press: DEBOUNCE identical non-NONE frames starting from idle; a mismatch
  // discards that frame. Release: DEBOUNCE consecutive frames not equal to the key.
  task automatic model_step(input logic [3:0] k);
    if (!m_en) begin
      if (m_run == 0) begin
        if (k != 4'hF) begin m_cand = k; m_run = 1; end
      end else if (k == m_cand) m_run++;
      else m_run = 0;
      if (m_run >= DEBOUNCE) begin m_en = 1'b1; m_key = m_cand; m_run = 0; end
    end else begin
      if (k == m_key) m_run = 0;
      else begin
        m_run++;
        if (m_run >= DEBOUNCE) begin m_en = 1'b0; m_run = 0; end
      end
    end
  endtask

  // Entered just after a frame boundary (or reset release); leaves 1 ns after
  // the edge that closes the frame.
  task automatic do_frame(input logic [15:0] mask);
    pressed = mask;
    check("col_start", col_out, 4'b1110);
    @(posedge CLK); #1;
    check("en", EN, m_en);
    check("key_value", key_value, m_key);
    for (int k = 2; k <= FRAME; k++) begin
      @(posedge CLK); #1;
      if (k % SCAN_DIV == 0 && k < FRAME)
        check("col_step", col_out, 4'(~(4'b0001 << (k / SCAN_DIV))));
    end
    model_step(frame_of(mask));
  endtask

  task automatic hold(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) do_frame(mask);
  endtask

  task automatic pulse_reset();
    #2 RST = 1'b1;
    #1;
    check("rst_en", EN, 0);
    check("rst_key", key_value, 4'hF);
    check("rst_col", col_out, 4'b1110);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] mask;
    int          falls0;
    int          r;
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // reset state and idle scanning
    hold(16'h0000, 2);

    // clean press of key (1,2), then release
    hold(16'h0040, 5);
    hold(16'h0000, 4);

    // bounce on key 0, then steady
    for (int i = 0; i < 10; i++) do_frame((i % 2 == 0) ? 16'h0001 : 16'h0000);
    hold(16'h0001, 4);
    hold(16'h0000, 4);

    // multi-key rejected, then single key accepted
    hold(16'h0021, 4);
    hold(16'h0001, 4);
    hold(16'h0000, 4);

    // one-frame release glitch on CONFIRM must not drop EN
    hold(16'h0800, 4);
    falls0 = en_falls;
    do_frame(16'h0000);
    hold(16'h0800, 3);
    check("glitch_no_fall", en_falls, falls0);
    hold(16'h0000, 4);

    // asynchronous reset while START is held
    hold(16'h0008, 4);
    pulse_reset();
    hold(16'h0008, 5);
    hold(16'h0000, 4);

    // randomized key activity with persistence
    mask = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r >= 6 && r <= 7) mask = 16'(1) << $urandom_range(0, 15);
      else if (r == 8) mask = 16'h0000;
      else if (r == 9) mask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      do_frame(mask);
    end
    hold(16'h0000, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
